// File: rtl/input_debouncer.sv
`default_nettype none
// ============================================================================
//  Module      : input_debouncer
//  Description : Two-flop synchronizer plus stability-count FSM that turns a
//                bouncing asynchronous input into a clean level with
//                one-cycle rise/fall pulses.
//  Revision    : 1.0  initial release
// ============================================================================

module input_debouncer #(
  parameter int STABLE_CYCLES = 8,
  parameter int CNT_WIDTH     = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  localparam logic [CNT_WIDTH-1:0] c_cnt_last = CNT_WIDTH'(STABLE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] c_cnt_one  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] c_cnt_zero = '0;

  typedef enum logic [1:0] {
    IDLE_LO = 2'd0,
    WAIT_HI = 2'd1,
    IDLE_HI = 2'd2,
    WAIT_LO = 2'd3
  } state_t;

  logic                 r_s1;
  logic                 r_s2;
  state_t               r_state;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 r_dout;
  logic                 r_rise;
  logic                 r_fall;

  state_t               w_state_nxt;
  logic [CNT_WIDTH-1:0] w_cnt_nxt;
  logic                 w_dout_nxt;
  logic                 w_rise_nxt;
  logic                 w_fall_nxt;

  // rst is active-low and asynchronous; only r_s2 is safe to use downstream
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= din;
      r_s2 <= r_s1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE_LO;
      r_cnt   <= c_cnt_zero;
      r_dout  <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_dout  <= w_dout_nxt;
      r_rise  <= w_rise_nxt;
      r_fall  <= w_fall_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_dout_nxt  = r_dout;
    w_rise_nxt  = 1'b0;
    w_fall_nxt  = 1'b0;
    unique case (r_state)
      IDLE_LO: begin
        if (r_s2) begin
          w_state_nxt = WAIT_HI;
          w_cnt_nxt   = c_cnt_zero;
        end
      end
      WAIT_HI: begin
        if (!r_s2) begin
          w_state_nxt = IDLE_LO;
          w_cnt_nxt   = c_cnt_zero;
        end else if (r_cnt == c_cnt_last) begin
          w_state_nxt = IDLE_HI;
          w_cnt_nxt   = c_cnt_zero;
          w_dout_nxt  = 1'b1;
          w_rise_nxt  = 1'b1;
        end else begin
          w_cnt_nxt   = r_cnt + c_cnt_one;
        end
      end
      IDLE_HI: begin
        if (!r_s2) begin
          w_state_nxt = WAIT_LO;
          w_cnt_nxt   = c_cnt_zero;
        end
      end
      WAIT_LO: begin
        if (r_s2) begin
          w_state_nxt = IDLE_HI;
          w_cnt_nxt   = c_cnt_zero;
        end else if (r_cnt == c_cnt_last) begin
          w_state_nxt = IDLE_LO;
          w_cnt_nxt   = c_cnt_zero;
          w_dout_nxt  = 1'b0;
          w_fall_nxt  = 1'b1;
        end else begin
          w_cnt_nxt   = r_cnt + c_cnt_one;
        end
      end
      default: begin
        w_state_nxt = IDLE_LO;
        w_cnt_nxt   = c_cnt_zero;
        w_dout_nxt  = 1'b0;
      end
    endcase
  end

  assign dout = r_dout;
  assign rise = r_rise;
  assign fall = r_fall;

endmodule

`default_nettype wire

// File: tb/tb_input_debouncer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_input_debouncer
//  Description : Scoreboard bench for input_debouncer: directed scenarios then
//                random hold/bounce segments against a run-length model.
//  Revision    : 1.0  initial release
// ============================================================================

module tb_input_debouncer;

  localparam int STABLE = 8;

  logic clk;
  logic rst;
  logic din;
  logic dout;
  logic rise;
  logic fall;

  int n_vec;
  int n_err;

  // expected {dout, rise, fall} after each rising edge, in edge order
  logic [2:0] exp_q[$];
  // samples still travelling to the decision point (the two sync stages)
  logic       pipe_q[$];
  logic       m_level;
  int         m_run;

  input_debouncer #(
    .STABLE_CYCLES(STABLE),
    .CNT_WIDTH    (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .din (din),
    .dout(dout),
    .rise(rise),
    .fall(fall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Accepted level changes once STABLE+1 consecutive samples disagree with it;
  // each sample reaches the decision two edges after it is taken.
  task automatic model_reset();
    m_level = 1'b0;
    m_run   = 0;
    pipe_q.delete();
    pipe_q.push_back(1'b0);
    pipe_q.push_back(1'b0);
    exp_q.delete();
  endtask

  task automatic model_step(input logic d);
    logic s;
    logic r;
    logic f;
    r = 1'b0;
    f = 1'b0;
    pipe_q.push_back(d);
    s = pipe_q.pop_front();
    if (s != m_level) begin
      m_run = m_run + 1;
      if (m_run == STABLE + 1) begin
        m_level = s;
        m_run   = 0;
        r = s;
        f = ~s;
      end
    end else begin
      m_run = 0;
    end
    exp_q.push_back({m_level, r, f});
  endtask

  task automatic cycle(input logic d);
    @(negedge clk);
    din = d;
    model_step(d);
  endtask

  task automatic hold(input logic d, input int n);
    for (int i = 0; i < n; i++) cycle(d);
  endtask

  task automatic do_reset(input logic d);
    @(negedge clk);
    #2;
    rst = 1'b0;
    din = d;
    #1;
    n_vec++;
    if ({dout, rise, fall} !== 3'b000) begin
      n_err++;
      $display("FAIL async_reset t=%0t got dout/rise/fall=%b required 000", $time, {dout, rise, fall});
    end
    model_reset();
    repeat (2) @(negedge clk);
    n_vec++;
    if ({dout, rise, fall} !== 3'b000) begin
      n_err++;
      $display("FAIL reset_hold t=%0t got dout/rise/fall=%b required 000", $time, {dout, rise, fall});
    end
  endtask

  task automatic release_rst(input logic d);
    @(negedge clk);
    rst = 1'b1;
    din = d;
    model_step(d);
  endtask

  // Monitor: every edge out of reset presents an output to score.
  initial begin
    logic [2:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (rst && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_vec++;
        if ({dout, rise, fall} !== e) begin
          n_err++;
          $display("FAIL edge_check t=%0t got dout/rise/fall=%b required %b", $time, {dout, rise, fall}, e);
        end
      end
    end
  end

  initial begin
    logic lvl;
    n_vec = 0;
    n_err = 0;
    rst   = 1'b0;
    din   = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    n_vec++;
    if ({dout, rise, fall} !== 3'b000) begin
      n_err++;
      $display("FAIL power_on_reset got dout/rise/fall=%b required 000", {dout, rise, fall});
    end

    release_rst(1'b0);
    hold(1'b0, 4);

    // clean rise, then async reset while dout is high
    hold(1'b1, 14);
    do_reset(1'b1);
    release_rst(1'b0);
    hold(1'b0, 4);

    // glitch shorter than the acceptance window
    hold(1'b1, 5);
    hold(1'b0, 12);

    // bounce ending high
    for (int t = 0; t < 6; t++) hold(t[0] ? 1'b0 : 1'b1, 2);
    hold(1'b1, 14);

    // clean fall
    hold(1'b0, 14);

    // reset mid-WAIT_HI, released with din high
    hold(1'b1, 7);
    do_reset(1'b1);
    release_rst(1'b1);
    hold(1'b1, 14);
    hold(1'b0, 14);

    // exact boundary: STABLE and STABLE+1 samples
    hold(1'b1, STABLE);
    hold(1'b0, 6);
    hold(1'b1, STABLE + 1);
    hold(1'b0, 14);

    // random segments around the acceptance threshold
    lvl = 1'b0;
    for (int s = 0; s < 150; s++) begin
      lvl = ~lvl;
      hold(lvl, $urandom_range(1, 14));
      if ($urandom_range(0, 39) == 0) begin
        do_reset(lvl);
        release_rst(lvl);
      end
    end
    hold(1'b0, 14);

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain got %0d pending required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/input_debouncer.md
# input_debouncer

Conditions a raw, asynchronous, possibly bouncing single-bit input (push-button, switch, external strobe) into a clean, clock-synchronous level that drives the data input `d` of the downstream D flip-flop stage. It synchronizes the input, requires it to hold a new value for a programmable number of cycles before accepting it, and emits one-cycle rise/fall pulses when the accepted level changes.

## Interface
- `STABLE_CYCLES`, default 8: consecutive synchronized samples of the new value required before `dout` changes. Legal range 2..2^`CNT_WIDTH`.
- `CNT_WIDTH`, default 4: width of the stability counter.
- `clk`  input  1  system clock; all state updates on the rising edge.
- `rst`  input  1  asynchronous, active-low reset. Single clock domain; reset polarity and asynchronous behaviour are fixed.
- `din`  input  1  raw asynchronous input.
- `dout`  output  1  debounced level. Feeds the downstream flip-flop `d`.
- `rise`  output  1  one-cycle pulse when `dout` goes 0->1.
- `fall`  output  1  one-cycle pulse when `dout` goes 1->0.

## Operation
- Synchronizer: two flops, `din -> s1 -> s2`. Both reset to 0. Only `s2` is used downstream.
- FSM states:
  - `IDLE_LO`: `dout` = 0. If `s2` = 1, go to `WAIT_HI` and set cnt = 0.
  - `WAIT_HI`: if `s2` = 0, return to `IDLE_LO` with cnt = 0. No output change.
    - Else if cnt = `STABLE_CYCLES`-1, go to `IDLE_HI`, set `dout` = 1 and `rise` = 1.
    - Else cnt += 1.
  - `IDLE_HI`: `dout` = 1. If `s2` = 0, go to `WAIT_LO` and set cnt = 0.
  - `WAIT_LO`: mirror of `WAIT_HI` with the polarity inverted. On commit, go to `IDLE_LO`, set `dout` = 0 and `fall` = 1.
- Counter rules:
  - Unsigned, `CNT_WIDTH` bits.
  - Never exceeds `STABLE_CYCLES`-1, so no wrap-around.
  - Cleared on every entry to a WAIT state and on every abort.
- `dout`, `rise` and `fall` are registered outputs, not decoded combinationally from state.
- `rise` and `fall` are never high in the same cycle. Each is high for exactly one cycle per committed transition.
- Any bounce during a WAIT state aborts that attempt. The stability count restarts from 0 on the next qualifying sample, so bouncing only delays acceptance.

## Timing
- Reset:
  - While `rst` = 0: `s1`, `s2`, cnt, `dout`, `rise` and `fall` are all 0, and the state is `IDLE_LO`.
  - These values take effect immediately, without a clock edge.
  - Reset mid-WAIT discards the attempt. No pulse is emitted.
- Latency:
  - Let edge k be the first rising edge that samples `din` at its new value.
  - If `din` is sampled at that value on edges k..k+`STABLE_CYCLES` (`STABLE_CYCLES`+1 samples), `dout` and the pulse update on edge k+`STABLE_CYCLES`+2.
  - With the default of 8, this is edge k+10.
- Minimum accepted pulse width on `din`: `STABLE_CYCLES`+1 clock periods. Anything shorter produces no change on `dout`.
- Transition order:
  - `rise`/`fall` goes high on the same edge `dout` changes and clears on the following edge.
  - Back-to-back opposite transitions are separated by at least `STABLE_CYCLES`+1 cycles.
- Reset release: `din` is first sampled on the first rising edge after `rst` goes high. That edge counts as edge k if `din` = 1.

## Test plan
All scenarios use `STABLE_CYCLES` = 8 and a 10 ns clock.
- Async reset: drive `rst` = 0 mid-cycle with `din` = 1 while `dout` = 1 -> `dout`, `rise` and `fall` are 0 before the next clock edge.
- Clean rise: `din` 0->1 sampled first at edge k, then held -> `dout` = 1 at edge k+10. `rise` = 1 for exactly one cycle. `fall` stays 0.
- Glitch reject: `din` = 1 for 5 cycles, then 0 -> `dout` stays 0, and `rise`/`fall` never assert.
- Bounce: `din` toggles every 2 cycles for 6 toggles and ends at 1, with the last 0->1 sampled at edge k -> `dout` = 1 at edge k+10. Exactly one `rise` pulse.
- Clean fall: from `dout` = 1, `din` 1->0 sampled at edge k -> `dout` = 0 at edge k+10. `fall` pulses for one cycle.
- Reset mid-WAIT: assert `rst` 5 cycles into `WAIT_HI`, then release with `din` = 1 -> no `rise` during or after the reset. `dout` = 1 at edge k+10, where k is the first edge after release.
